// File: rtl/cpu_core_pkg.sv
// Shared core types for the integer pipeline.
//
// Contents:
//   gpr_idx_t - 5-bit MIPS general purpose register number
//   GPR_ZERO  - register $0, hardwired to zero and never tracked
//   NUM_GPR   - number of architectural GPRs
package cpu_core_pkg;

  typedef logic [4:0] gpr_idx_t;

  localparam gpr_idx_t GPR_ZERO = 5'd0;
  localparam int       NUM_GPR  = 32;

endpackage : cpu_core_pkg

// File: rtl/decoder_5_to_32.sv
// Enabled 5-to-32 one-hot decoder.
//
// Ports:
//   en     in   1   output is all-zero when low
//   idx    in   5   register number to select
//   onehot out  32  onehot[idx] = en, all other bits 0
module decoder_5_to_32
  import cpu_core_pkg::*;
(
  input  logic                en,
  input  gpr_idx_t            idx,
  output logic [NUM_GPR-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule : decoder_5_to_32

// File: rtl/reg_scoreboard.sv
// GPR write scoreboard.
//
// Tracks writes to the 32 GPRs between issue and writeback so decode can stall
// on RAW hazards against long-latency results. Each register has its own
// pending counter, so several writes to the same GPR may be in flight (WAW).
//
// Handshake: issue_valid/issue_ready follow strict valid/ready semantics. An
// instruction is accepted in a cycle where both are high. issue_ready is
// purely combinational from scoreboard state, the source/dest fields, the
// writeback port and flush; it never looks at issue_valid, so decode may make
// issue_valid depend on issue_ready but not the other way round.
//
// Ports:
//   clock          in   1   core clock, rising edge
//   reset_n        in   1   asynchronous active-low reset
//   flush          in   1   drop all pending state; issue/wb this cycle ignored
//   issue_valid    in   1   decode offers an instruction
//   issue_ready    out  1   no RAW hazard, no counter saturation, no flush
//   issue_dest_we  in   1   instruction writes a GPR
//   issue_dest     in   5   destination GPR
//   src0_used      in   1   rs is read
//   src0_addr      in   5   rs number
//   src1_used      in   1   rt is read
//   src1_addr      in   5   rt number
//   wb_valid       in   1   writeback retires one GPR write
//   wb_dest        in   5   GPR being written back
//   busy           out  32  busy[i] = pending counter i non-zero
//   err_underflow  out  1   sticky: retire seen on a register with nothing pending
module reg_scoreboard
  import cpu_core_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                issue_dest_we,
  input  gpr_idx_t            issue_dest,
  input  logic                src0_used,
  input  gpr_idx_t            src0_addr,
  input  logic                src1_used,
  input  gpr_idx_t            src1_addr,
  input  logic                wb_valid,
  input  gpr_idx_t            wb_dest,
  output logic [NUM_GPR-1:0]  busy,
  output logic                err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]   cnt [NUM_GPR];

  logic               retire;
  logic [CNT_W-1:0]   cnt_src0;
  logic [CNT_W-1:0]   cnt_src1;
  logic [CNT_W-1:0]   cnt_dest;
  logic [CNT_W-1:0]   cnt_wb;
  logic               haz0;
  logic               haz1;
  logic               sat;
  logic               issue_fire;
  logic               inc_en;
  logic               dec_en;
  logic               underflow_hit;
  logic [NUM_GPR-1:0] inc_oh;
  logic [NUM_GPR-1:0] dec_oh;

  // $0 is never written, so a writeback to it is not a retire.
  assign retire = wb_valid && (wb_dest != GPR_ZERO);

  assign cnt_src0 = cnt[src0_addr];
  assign cnt_src1 = cnt[src1_addr];
  assign cnt_dest = cnt[issue_dest];
  assign cnt_wb   = cnt[wb_dest];

  // A source is hazardous while a write to it is pending, unless this cycle's
  // writeback retires the last one: the value is forwarded from writeback.
  always_comb begin
    haz0 = src0_used && (src0_addr != GPR_ZERO) && (cnt_src0 != '0) &&
           !(retire && (wb_dest == src0_addr) && (cnt_src0 == CNT_ONE));
    haz1 = src1_used && (src1_addr != GPR_ZERO) && (cnt_src1 != '0) &&
           !(retire && (wb_dest == src1_addr) && (cnt_src1 == CNT_ONE));
  end

  // A full counter can still accept a new write when the same register
  // retires in this cycle: the increment and decrement cancel.
  assign sat = issue_dest_we && (issue_dest != GPR_ZERO) && (cnt_dest == CNT_MAX) &&
               !(retire && (wb_dest == issue_dest));

  assign issue_ready = !haz0 && !haz1 && !sat && !flush;
  assign issue_fire  = issue_valid && issue_ready;

  // issue_ready is low during flush, so inc_en is already masked by flush.
  assign inc_en = issue_fire && issue_dest_we && (issue_dest != GPR_ZERO);
  assign dec_en = retire && !flush;

  decoder_5_to_32 u_inc_dec (
    .en     (inc_en),
    .idx    (issue_dest),
    .onehot (inc_oh)
  );

  decoder_5_to_32 u_dec_dec (
    .en     (dec_en),
    .idx    (wb_dest),
    .onehot (dec_oh)
  );

  // Per-register pending counters. A same-cycle increment and retire leave
  // the counter unchanged, including on an empty counter; neither direction
  // ever wraps.
  for (genvar i = 0; i < NUM_GPR; i++) begin : g_slot
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt[i] <= '0;
      end else if (flush) begin
        cnt[i] <= '0;
      end else if (inc_oh[i] && !dec_oh[i] && (cnt[i] != CNT_MAX)) begin
        cnt[i] <= cnt[i] + CNT_ONE;
      end else if (dec_oh[i] && !inc_oh[i] && (cnt[i] != '0)) begin
        cnt[i] <= cnt[i] - CNT_ONE;
      end
    end

    assign busy[i] = (cnt[i] != '0);
  end

  // Retire on an empty counter with no matching issue is a protocol error.
  assign underflow_hit = dec_en && (cnt_wb == '0) &&
                         !(inc_en && (issue_dest == wb_dest));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_underflow <= 1'b0;
    end else if (underflow_hit) begin
      err_underflow <= 1'b1;
    end
  end

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. Each cycle the driver applies inputs just
// after the rising edge and queues the expected {issue_ready, err_underflow,
// busy} for that cycle; the monitor pops and compares on the falling edge.
module tb_reg_scoreboard;
  import cpu_core_pkg::*;

  localparam int W = 34;

  logic                clock;
  logic                reset_n;
  logic                flush;
  logic                issue_valid;
  logic                issue_ready;
  logic                issue_dest_we;
  gpr_idx_t            issue_dest;
  logic                src0_used;
  gpr_idx_t            src0_addr;
  logic                src1_used;
  gpr_idx_t            src1_addr;
  logic                wb_valid;
  gpr_idx_t            wb_dest;
  logic [NUM_GPR-1:0]  busy;
  logic                err_underflow;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           total;
  int           bad;

  reg_scoreboard #(.CNT_W(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_dest_we (issue_dest_we),
    .issue_dest    (issue_dest),
    .src0_used     (src0_used),
    .src0_addr     (src0_addr),
    .src1_used     (src1_used),
    .src1_addr     (src1_addr),
    .wb_valid      (wb_valid),
    .wb_dest       (wb_dest),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    flush         = 1'b0;
    issue_valid   = 1'b0;
    issue_dest_we = 1'b0;
    issue_dest    = '0;
    src0_used     = 1'b0;
    src0_addr     = '0;
    src1_used     = 1'b0;
    src1_addr     = '0;
    wb_valid      = 1'b0;
    wb_dest       = '0;
  endtask

  task automatic issue(input logic v, input logic we, input logic [4:0] d,
                       input logic s0u, input logic [4:0] s0,
                       input logic s1u, input logic [4:0] s1);
    issue_valid   = v;
    issue_dest_we = we;
    issue_dest    = d;
    src0_used     = s0u;
    src0_addr     = s0;
    src1_used     = s1u;
    src1_addr     = s1;
  endtask

  task automatic wb(input logic v, input logic [4:0] d);
    wb_valid = v;
    wb_dest  = d;
  endtask

  task automatic push_exp(input string tag, input logic rdy, input logic err,
                          input logic [31:0] bsy);
    exp_q.push_back({rdy, err, bsy});
    tag_q.push_back(tag);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (issue_ready !== e[33]) begin
        bad++;
        $display("FAIL %s ready: got=%b want=%b", t, issue_ready, e[33]);
      end
      total++;
      if (err_underflow !== e[32]) begin
        bad++;
        $display("FAIL %s err_underflow: got=%b want=%b", t, err_underflow, e[32]);
      end
      total++;
      if (busy !== e[31:0]) begin
        bad++;
        $display("FAIL %s busy: got=%h want=%h", t, busy, e[31:0]);
      end
    end
  end

  // stimulus
  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    idle_in();
    #1;
    push_exp("rst_init", 1'b1, 1'b0, 32'h0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    push_exp("post_rst", 1'b1, 1'b0, 32'h0);

    // reset mid-count, with the underflow flag set beforehand
    next_cycle(); idle_in(); issue(1, 1, 5, 0, 0, 0, 0); wb(1, 20);
    push_exp("t1_issue5", 1'b1, 1'b0, 32'h0);
    next_cycle(); idle_in(); issue(1, 1, 6, 0, 0, 0, 0);
    push_exp("t1_issue6", 1'b1, 1'b1, 32'h20);
    next_cycle(); idle_in(); issue(0, 0, 0, 1, 5, 0, 0);
    push_exp("t1_raw5", 1'b0, 1'b1, 32'h60);
    next_cycle(); reset_n = 1'b0;
    push_exp("t1_async_rst", 1'b1, 1'b0, 32'h0);
    next_cycle(); reset_n = 1'b1; idle_in();
    push_exp("t1_rst_rel", 1'b1, 1'b0, 32'h0);

    // RAW stall and writeback forwarding on both source ports
    next_cycle(); idle_in(); issue(1, 1, 8, 0, 0, 0, 0);
    push_exp("t2_issue8", 1'b1, 1'b0, 32'h0);
    next_cycle(); idle_in(); issue(1, 0, 0, 1, 8, 0, 0);
    push_exp("t2_raw_stall", 1'b0, 1'b0, 32'h100);
    next_cycle(); idle_in(); issue(1, 0, 0, 1, 8, 0, 0); wb(1, 8);
    push_exp("t2_wb_fwd", 1'b1, 1'b0, 32'h100);
    next_cycle(); idle_in(); issue(1, 1, 9, 0, 0, 0, 0);
    push_exp("t2_after_wb", 1'b1, 1'b0, 32'h0);
    next_cycle(); idle_in(); issue(1, 0, 0, 0, 0, 1, 9);
    push_exp("t2_raw_src1", 1'b0, 1'b0, 32'h200);
    next_cycle(); idle_in(); issue(1, 0, 0, 0, 0, 1, 9); wb(1, 9);
    push_exp("t2_src1_fwd", 1'b1, 1'b0, 32'h200);
    next_cycle(); idle_in();
    push_exp("t2_clear", 1'b1, 1'b0, 32'h0);

    // WAW and saturation on reg 3
    next_cycle(); idle_in(); issue(1, 1, 3, 0, 0, 0, 0);
    push_exp("t3_issue_a", 1'b1, 1'b0, 32'h0);
    next_cycle(); idle_in(); issue(1, 1, 3, 0, 0, 0, 0);
    push_exp("t3_issue_b", 1'b1, 1'b0, 32'h8);
    next_cycle(); idle_in(); issue(1, 1, 3, 0, 0, 0, 0);
    push_exp("t3_issue_c", 1'b1, 1'b0, 32'h8);
    next_cycle(); idle_in(); issue(1, 1, 3, 0, 0, 0, 0);
    push_exp("t3_sat", 1'b0, 1'b0, 32'h8);
    next_cycle(); idle_in(); issue(1, 1, 3, 0, 0, 0, 0); wb(1, 3);
    push_exp("t3_sat_wb", 1'b1, 1'b0, 32'h8);
    next_cycle(); idle_in(); issue(0, 1, 3, 0, 0, 0, 0);
    push_exp("t3_still_sat", 1'b0, 1'b0, 32'h8);
    next_cycle(); idle_in(); wb(1, 3);
    push_exp("t3_wb1", 1'b1, 1'b0, 32'h8);
    next_cycle(); idle_in(); wb(1, 3);
    push_exp("t3_wb2", 1'b1, 1'b0, 32'h8);
    next_cycle(); idle_in(); wb(1, 3);
    push_exp("t3_wb3", 1'b1, 1'b0, 32'h8);
    next_cycle(); idle_in();
    push_exp("t3_clear", 1'b1, 1'b0, 32'h0);

    // $0 is never tracked; same-cycle issue+retire on an empty counter nets zero
    next_cycle(); idle_in(); issue(1, 1, 0, 1, 0, 0, 0);
    push_exp("t4_zero_a", 1'b1, 1'b0, 32'h0);
    next_cycle(); idle_in(); issue(1, 1, 0, 1, 0, 0, 0); wb(1, 0);
    push_exp("t4_zero_b", 1'b1, 1'b0, 32'h0);
    next_cycle(); idle_in(); issue(1, 1, 0, 1, 0, 0, 0);
    push_exp("t4_zero_c", 1'b1, 1'b0, 32'h0);
    next_cycle(); idle_in(); issue(1, 1, 14, 0, 0, 0, 0); wb(1, 14);
    push_exp("t4_inc_wb_zero", 1'b1, 1'b0, 32'h0);
    next_cycle(); idle_in();
    push_exp("t4_net_zero", 1'b1, 1'b0, 32'h0);

    // underflow is sticky and leaves the counter at 0
    next_cycle(); idle_in(); wb(1, 12);
    push_exp("t5_uf_wb", 1'b1, 1'b0, 32'h0);
    next_cycle(); idle_in(); issue(0, 0, 0, 1, 12, 0, 0);
    push_exp("t5_uf_set", 1'b1, 1'b1, 32'h0);
    next_cycle(); idle_in();
    push_exp("t5_uf_sticky", 1'b1, 1'b1, 32'h0);

    // flush drops pending state and ignores same-cycle issue/wb
    next_cycle(); idle_in(); issue(1, 1, 2, 0, 0, 0, 0);
    push_exp("t6_issue2", 1'b1, 1'b1, 32'h0);
    next_cycle(); idle_in(); issue(1, 1, 9, 0, 0, 0, 0);
    push_exp("t6_issue9", 1'b1, 1'b1, 32'h4);
    next_cycle(); idle_in(); flush = 1'b1; issue(1, 1, 4, 0, 0, 0, 0); wb(1, 2);
    push_exp("t6_flush", 1'b0, 1'b1, 32'h204);
    next_cycle(); idle_in();
    push_exp("t6_after", 1'b1, 1'b1, 32'h0);
    next_cycle(); idle_in();
    push_exp("t6_settle", 1'b1, 1'b1, 32'h0);

    next_cycle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_scoreboard
